program_counter_unit: RTL and testbench

PROGRAM_COUNTER_UNIT -- requirements
Module: program_counter_unit

---
 rtl/program_counter_unit_pkg.sv | 52 +++++
 rtl/pc_next_select.sv | 31 +++
 rtl/program_counter_unit.sv | 105 ++++++++++
 tb/tb_program_counter_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/program_counter_unit_pkg.sv
// Shared processor definitions: opcode map, PC FSM states and address width default.
// Also used by the decoder and the return-address filter.
package program_counter_unit_pkg;

  localparam int unsigned AddrWidthDefault = 12;
  localparam int unsigned OpWidth          = 6;

  // Opcodes 000000..OpSeqLast are plain sequential instructions.
  localparam logic [OpWidth-1:0] OpSeqLast = 6'b010001;
  localparam logic [OpWidth-1:0] OpJmp     = 6'b010010;
  localparam logic [OpWidth-1:0] OpBrt     = 6'b010011;
  localparam logic [OpWidth-1:0] OpBrf     = 6'b010100;
  localparam logic [OpWidth-1:0] OpJr      = 6'b010101;
  localparam logic [OpWidth-1:0] OpHlt     = 6'b010110;
  localparam logic [OpWidth-1:0] OpIn      = 6'b010111;

  typedef enum logic [1:0] {
    StRun,
    StWaitIn,
    StHalted
  } pc_state_e;

  typedef enum logic [2:0] {
    OpcSeq,
    OpcJmp,
    OpcBrt,
    OpcBrf,
    OpcJr,
    OpcHlt,
    OpcIn,
    OpcIllegal
  } op_class_e;

  function automatic op_class_e decode_op(logic [OpWidth-1:0] op);
    op_class_e cls;
    if (op <= OpSeqLast) begin
      cls = OpcSeq;
    end else begin
      case (op)
        OpJmp:   cls = OpcJmp;
        OpBrt:   cls = OpcBrt;
        OpBrf:   cls = OpcBrf;
        OpJr:    cls = OpcJr;
        OpHlt:   cls = OpcHlt;
        OpIn:    cls = OpcIn;
        default: cls = OpcIllegal;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/pc_next_select.sv
// Combinational next-address mux for the flow-control opcodes.
// Non-flow opcodes fall through to PC+1; the FSM decides whether the result is used.
module pc_next_select
  import program_counter_unit_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = AddrWidthDefault
) (
  input  logic [ADDRESS_WIDTH-1:0] pc,
  input  logic [OpWidth-1:0]       operation,
  input  logic [ADDRESS_WIDTH-1:0] immediate_target,
  input  logic [ADDRESS_WIDTH-1:0] register_target,
  input  logic                     condition_flag,
  output logic [ADDRESS_WIDTH-1:0] pc_plus_one,
  output logic [ADDRESS_WIDTH-1:0] next_pc
);

  // Truncation to ADDRESS_WIDTH gives the required silent wrap.
  assign pc_plus_one = pc + {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    next_pc = pc_plus_one;
    unique case (decode_op(operation))
      OpcJmp:  next_pc = immediate_target;
      OpcBrt:  next_pc = condition_flag ? immediate_target : pc_plus_one;
      OpcBrf:  next_pc = condition_flag ? pc_plus_one : immediate_target;
      OpcJr:   next_pc = register_target;
      default: next_pc = pc_plus_one;
    endcase
  end

endmodule

// File: rtl/program_counter_unit.sv
// Program counter with RUN / WAIT_IN / HALTED sequencing, IN handshake and sticky
// illegal-opcode trap. All state advances only on enabled clock edges.
module program_counter_unit
  import program_counter_unit_pkg::*;
#(
  parameter int unsigned            ADDRESS_WIDTH = AddrWidthDefault,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_ADDRESS = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [OpWidth-1:0]       operation,
  input  logic [ADDRESS_WIDTH-1:0] immediate_target,
  input  logic [ADDRESS_WIDTH-1:0] register_target,
  input  logic                     condition_flag,
  input  logic                     in_valid,
  input  logic                     resume,
  output logic [ADDRESS_WIDTH-1:0] program_counter,
  output logic                     in_ack,
  output logic                     halted,
  output logic                     illegal_op
);

  pc_state_e                state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic                     illegal_q, illegal_d;
  logic                     ack_raw;
  logic [ADDRESS_WIDTH-1:0] pc_plus_one;
  logic [ADDRESS_WIDTH-1:0] flow_next_pc;

  pc_next_select #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_pc_next_select (
    .pc              (pc_q),
    .operation       (operation),
    .immediate_target(immediate_target),
    .register_target (register_target),
    .condition_flag  (condition_flag),
    .pc_plus_one     (pc_plus_one),
    .next_pc         (flow_next_pc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StRun;
      pc_q      <= RESET_ADDRESS;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    illegal_d = illegal_q;
    ack_raw   = 1'b0;
    if (enable) begin
      unique case (state_q)
        StRun: begin
          unique case (decode_op(operation))
            OpcHlt: state_d = StHalted;
            OpcIn: begin
              if (in_valid) begin
                ack_raw = 1'b1;
                pc_d    = pc_plus_one;
              end else begin
                state_d = StWaitIn;
              end
            end
            OpcIllegal: begin
              illegal_d = 1'b1;
              state_d   = StHalted;
            end
            default: pc_d = flow_next_pc;
          endcase
        end
        StWaitIn: begin
          if (in_valid) begin
            ack_raw = 1'b1;
            pc_d    = pc_plus_one;
            state_d = StRun;
          end
        end
        StHalted: begin
          // An illegal-opcode halt is terminal until reset.
          if (resume && !illegal_q) begin
            pc_d    = pc_plus_one;
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  // Gate with reset so an abandoned handshake never acknowledges.
  assign in_ack          = ack_raw & reset;
  assign program_counter = pc_q;
  assign halted          = (state_q == StHalted);
  assign illegal_op      = illegal_q;

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed self-checking bench for program_counter_unit.
module tb_program_counter_unit;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [5:0]  operation;
  logic [11:0] immediate_target;
  logic [11:0] register_target;
  logic        condition_flag;
  logic        in_valid;
  logic        resume;
  logic [11:0] program_counter;
  logic        in_ack;
  logic        halted;
  logic        illegal_op;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] SEQ = 6'b000101;
  localparam logic [5:0] JMP = 6'b010010;
  localparam logic [5:0] BRT = 6'b010011;
  localparam logic [5:0] BRF = 6'b010100;
  localparam logic [5:0] JR  = 6'b010101;
  localparam logic [5:0] HLT = 6'b010110;
  localparam logic [5:0] IN  = 6'b010111;
  localparam logic [5:0] ILL = 6'b011000;

  program_counter_unit dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .operation       (operation),
    .immediate_target(immediate_target),
    .register_target (register_target),
    .condition_flag  (condition_flag),
    .in_valid        (in_valid),
    .resume          (resume),
    .program_counter (program_counter),
    .in_ack          (in_ack),
    .halted          (halted),
    .illegal_op      (illegal_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic jump_to(input logic [11:0] addr);
    operation        = JMP;
    immediate_target = addr;
    step();
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; operation = IN; immediate_target = '0;
    register_target = '0; condition_flag = 1'b0; in_valid = 1'b1; resume = 1'b0;
    #12;
    check("reset_pc", 32'(program_counter), 32'h000);
    check("reset_halted", 32'(halted), 0);
    check("reset_illegal", 32'(illegal_op), 0);
    check("reset_in_ack", 32'(in_ack), 0);

    // Three sequential cycles
    reset = 1'b1; enable = 1'b1; operation = SEQ; in_valid = 1'b0;
    step(); check("seq_1", 32'(program_counter), 32'h001);
    step(); check("seq_2", 32'(program_counter), 32'h002);
    step(); check("seq_3", 32'(program_counter), 32'h003);
    check("seq_halted", 32'(halted), 0);
    enable = 1'b0;
    step(); check("stall_seq", 32'(program_counter), 32'h003);
    enable = 1'b1;

    // Conditional branches
    jump_to(12'h010); check("jmp_010", 32'(program_counter), 32'h010);
    operation = BRT; immediate_target = 12'h200; condition_flag = 1'b0;
    step(); check("brt_not_taken", 32'(program_counter), 32'h011);
    jump_to(12'h010);
    operation = BRT; immediate_target = 12'h200; condition_flag = 1'b1;
    step(); check("brt_taken", 32'(program_counter), 32'h200);
    jump_to(12'h010);
    operation = BRF; immediate_target = 12'h200; condition_flag = 1'b1;
    step(); check("brf_not_taken", 32'(program_counter), 32'h011);
    jump_to(12'h010);
    operation = BRF; immediate_target = 12'h200; condition_flag = 1'b0;
    step(); check("brf_taken", 32'(program_counter), 32'h200);

    // IN with delayed data; the opcode is ignored while waiting
    jump_to(12'h020);
    operation = IN; in_valid = 1'b0;
    #1 check("in_no_valid_ack", 32'(in_ack), 0);
    step(); check("wait_pc_1", 32'(program_counter), 32'h020);
    operation = HLT;
    step(); check("wait_pc_2", 32'(program_counter), 32'h020);
    check("wait_not_halted", 32'(halted), 0);
    step(); check("wait_pc_3", 32'(program_counter), 32'h020);
    enable = 1'b0; in_valid = 1'b1;
    #1 check("wait_stall_ack", 32'(in_ack), 0);
    enable = 1'b1;
    #1 check("wait_ack", 32'(in_ack), 1);
    step(); check("wait_done_pc", 32'(program_counter), 32'h021);
    check("ack_single", 32'(in_ack), 0);
    operation = IN; in_valid = 1'b1;
    #1 check("in_immediate_ack", 32'(in_ack), 1);
    step(); check("in_immediate_pc", 32'(program_counter), 32'h022);
    in_valid = 1'b0;

    // Wrap, stall, register jump
    jump_to(12'hFFF);
    operation = SEQ;
    step(); check("wrap", 32'(program_counter), 32'h000);
    enable = 1'b0; operation = JR; register_target = 12'h5A5;
    step(); check("stall_jr", 32'(program_counter), 32'h000);
    enable = 1'b1;
    step(); check("jr", 32'(program_counter), 32'h5A5);

    // Halt and resume
    jump_to(12'h030);
    operation = HLT;
    step(); check("hlt_pc", 32'(program_counter), 32'h030);
    check("hlt_halted", 32'(halted), 1);
    operation = SEQ;
    step(); check("hlt_hold_pc", 32'(program_counter), 32'h030);
    resume = 1'b1;
    step(); check("resume_pc", 32'(program_counter), 32'h031);
    check("resume_run", 32'(halted), 0);

    // Illegal opcode traps; resume then has no effect
    resume = 1'b0; operation = ILL;
    step(); check("ill_flag", 32'(illegal_op), 1);
    check("ill_halted", 32'(halted), 1);
    check("ill_pc", 32'(program_counter), 32'h031);
    resume = 1'b1; operation = SEQ;
    step(); check("ill_resume_pc", 32'(program_counter), 32'h031);
    check("ill_still_halted", 32'(halted), 1);
    resume = 1'b0;

    // Asynchronous reset from HALTED
    #2 reset = 1'b0;
    #1 check("rst_halt_pc", 32'(program_counter), 32'h000);
    check("rst_halt_illegal", 32'(illegal_op), 0);
    check("rst_halt_halted", 32'(halted), 0);
    step();
    reset = 1'b1;

    // Reset during WAIT_IN with data arriving
    jump_to(12'h040);
    operation = IN; in_valid = 1'b0;
    step(); check("wait2_pc", 32'(program_counter), 32'h040);
    in_valid = 1'b1; reset = 1'b0;
    #1 check("rst_wait_ack", 32'(in_ack), 0);
    check("rst_wait_pc", 32'(program_counter), 32'h000);
    check("rst_wait_halted", 32'(halted), 0);
    step();
    reset = 1'b1; operation = SEQ; in_valid = 1'b0;
    step(); check("rst_wait_run", 32'(program_counter), 32'h001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
